// File: rtl/pll_seq_pkg.sv
// Shared types and helpers for the PLL reset sequencer and its synchronizer.
package pll_seq_pkg;

    typedef enum logic [2:0] {
        HOLD,
        WAIT_LOCK,
        STABLE,
        RUN,
        FAIL
    } seq_state_e;

    // Width of a counter able to hold (largest interval - 1).
    function automatic int cnt_width(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return (m < 2) ? 1 : $clog2(m);
    endfunction

    function automatic logic [3:0] sat_inc4(input logic [3:0] v);
        return (v == 4'hF) ? v : v + 4'd1;
    endfunction

endpackage

// File: rtl/bit_synchronizer.sv
// Multi-flop synchronizer for a single asynchronous bit, synchronous reset to 0.
module bit_synchronizer #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync_q;
    logic [STAGES-1:0] sync_d;

    always_comb begin
        sync_d = {sync_q[STAGES-2:0], d};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign q = sync_q[STAGES-1];

endmodule

// File: rtl/pll_reset_sequencer.sv
// Sequences PLL reset, lock qualification and system reset release in the refclk domain.
module pll_reset_sequencer
    import pll_seq_pkg::*;
#(
    parameter int RST_HOLD_CYCLES     = 16,
    parameter int LOCK_TIMEOUT_CYCLES = 65536,
    parameter int LOCK_STABLE_CYCLES  = 1024,
    parameter int MAX_RETRIES         = 7,
    parameter int SYNC_STAGES         = 2
) (
    input  logic       refclk,
    input  logic       rst,
    input  logic       pll_locked,
    input  logic       req_reset,
    output logic       pll_rst,
    output logic       sys_reset,
    output logic       ready,
    output logic       lock_fail,
    output logic [3:0] retry_count,
    output logic [3:0] lock_loss_count
);

    localparam int CW = cnt_width(RST_HOLD_CYCLES, LOCK_TIMEOUT_CYCLES, LOCK_STABLE_CYCLES);

    // The counter starts at zero on entry and counts down with wrap, so after
    // N-1 cycles in a state it holds -(N-1); that value marks the last cycle.
    localparam logic [CW-1:0] HOLD_END    = CW'(0 - (RST_HOLD_CYCLES - 1));
    localparam logic [CW-1:0] TIMEOUT_END = CW'(0 - (LOCK_TIMEOUT_CYCLES - 1));
    localparam logic [CW-1:0] STABLE_END  = CW'(0 - (LOCK_STABLE_CYCLES - 1));

    logic            lk;
    seq_state_e      state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [3:0]      retry_count_q, retry_count_d;
    logic [3:0]      lock_loss_count_q, lock_loss_count_d;
    logic            lock_fail_q, lock_fail_d;
    logic            pll_rst_q, pll_rst_d;
    logic            sys_reset_q, sys_reset_d;
    logic            ready_q, ready_d;

    bit_synchronizer #(
        .STAGES(SYNC_STAGES)
    ) u_lock_sync (
        .clk(refclk),
        .rst(rst),
        .d  (pll_locked),
        .q  (lk)
    );

    always_comb begin
        state_d           = state_q;
        cnt_d             = cnt_q - CW'(1);
        retry_count_d     = retry_count_q;
        lock_loss_count_d = lock_loss_count_q;
        lock_fail_d       = lock_fail_q;

        if (req_reset) begin
            state_d       = HOLD;
            cnt_d         = '0;
            retry_count_d = '0;
            lock_fail_d   = 1'b0;
        end else begin
            case (state_q)
                HOLD: begin
                    if (cnt_q == HOLD_END) begin
                        state_d = WAIT_LOCK;
                        cnt_d   = '0;
                    end
                end
                WAIT_LOCK: begin
                    if (lk) begin
                        state_d = STABLE;
                        cnt_d   = '0;
                    end else if (cnt_q == TIMEOUT_END) begin
                        cnt_d = '0;
                        if (retry_count_q == 4'(MAX_RETRIES)) begin
                            state_d     = FAIL;
                            lock_fail_d = 1'b1;
                        end else begin
                            state_d       = HOLD;
                            retry_count_d = retry_count_q + 4'd1;
                        end
                    end
                end
                STABLE: begin
                    if (!lk) begin
                        state_d = WAIT_LOCK;
                        cnt_d   = '0;
                    end else if (cnt_q == STABLE_END) begin
                        state_d       = RUN;
                        cnt_d         = '0;
                        retry_count_d = '0;
                    end
                end
                RUN: begin
                    cnt_d = '0;
                    if (!lk) begin
                        state_d           = HOLD;
                        lock_loss_count_d = sat_inc4(lock_loss_count_q);
                    end
                end
                FAIL: begin
                    cnt_d = '0;
                end
                default: begin
                    state_d = HOLD;
                    cnt_d   = '0;
                end
            endcase
        end

        // Outputs follow the next state so they change on the same edge as the state.
        pll_rst_d   = (state_d == HOLD) || (state_d == FAIL);
        sys_reset_d = (state_d != RUN);
        ready_d     = (state_d == RUN);
    end

    always_ff @(posedge refclk) begin
        if (rst) begin
            state_q           <= HOLD;
            cnt_q             <= '0;
            retry_count_q     <= '0;
            lock_loss_count_q <= '0;
            lock_fail_q       <= 1'b0;
            pll_rst_q         <= 1'b1;
            sys_reset_q       <= 1'b1;
            ready_q           <= 1'b0;
        end else begin
            state_q           <= state_d;
            cnt_q             <= cnt_d;
            retry_count_q     <= retry_count_d;
            lock_loss_count_q <= lock_loss_count_d;
            lock_fail_q       <= lock_fail_d;
            pll_rst_q         <= pll_rst_d;
            sys_reset_q       <= sys_reset_d;
            ready_q           <= ready_d;
        end
    end

    assign pll_rst         = pll_rst_q;
    assign sys_reset       = sys_reset_q;
    assign ready           = ready_q;
    assign lock_fail       = lock_fail_q;
    assign retry_count     = retry_count_q;
    assign lock_loss_count = lock_loss_count_q;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Bench for pll_reset_sequencer: timestamp-based reference model compared every cycle,
// directed scenarios with hand-computed expectations, then randomized lock/request traffic.
module tb_pll_reset_sequencer;

    localparam int HOLD_N    = 4;
    localparam int TIMEOUT_N = 32;
    localparam int STABLE_N  = 8;
    localparam int MAX_RETRY = 2;
    localparam int SYNC_N    = 2;

    logic       refclk = 1'b0;
    logic       rst = 1'b1;
    logic       req_reset = 1'b0;
    logic       pll_locked = 1'b0;
    logic       pll_rst, sys_reset, ready, lock_fail;
    logic [3:0] retry_count, lock_loss_count;

    int total_checks  = 0;
    int passed_checks = 0;

    pll_reset_sequencer #(
        .RST_HOLD_CYCLES    (HOLD_N),
        .LOCK_TIMEOUT_CYCLES(TIMEOUT_N),
        .LOCK_STABLE_CYCLES (STABLE_N),
        .MAX_RETRIES        (MAX_RETRY),
        .SYNC_STAGES        (SYNC_N)
    ) dut (
        .refclk         (refclk),
        .rst            (rst),
        .pll_locked     (pll_locked),
        .req_reset      (req_reset),
        .pll_rst        (pll_rst),
        .sys_reset      (sys_reset),
        .ready          (ready),
        .lock_fail      (lock_fail),
        .retry_count    (retry_count),
        .lock_loss_count(lock_loss_count)
    );

    always #5 refclk = ~refclk;

    task automatic checkOutput(input string name, input int actual, input int expected);
        total_checks++;
        if (actual == expected) passed_checks++;
        else $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    endtask

    // Reference model: phase plus the cycle it was entered; the synchronizer is a sample queue.
    typedef enum int {M_HOLD, M_WAIT, M_STABLE, M_RUN, M_FAIL} phase_e;
    phase_e m_phase = M_HOLD;
    int     m_cycle = 0;
    int     m_entry = 0;
    int     m_retry = 0;
    int     m_loss  = 0;
    bit     m_fail  = 1'b0;
    bit     m_valid = 1'b0;
    int     m_samp[$];

    task automatic model_enter(input phase_e p);
        m_phase = p;
        m_entry = m_cycle;
    endtask

    task automatic model_step();
        int lk;
        int dur;
        m_cycle++;
        lk = m_samp.pop_front();
        m_samp.push_back(int'(pll_locked));
        if (rst) begin
            model_enter(M_HOLD);
            m_retry = 0;
            m_loss  = 0;
            m_fail  = 1'b0;
            m_valid = 1'b1;
            m_samp.delete();
            for (int i = 0; i < SYNC_N; i++) m_samp.push_back(0);
        end else if (req_reset) begin
            model_enter(M_HOLD);
            m_retry = 0;
            m_fail  = 1'b0;
        end else begin
            dur = m_cycle - m_entry;
            case (m_phase)
                M_HOLD: if (dur == HOLD_N) model_enter(M_WAIT);
                M_WAIT: begin
                    if (lk == 1) model_enter(M_STABLE);
                    else if (dur == TIMEOUT_N) begin
                        if (m_retry == MAX_RETRY) begin
                            model_enter(M_FAIL);
                            m_fail = 1'b1;
                        end else begin
                            m_retry++;
                            model_enter(M_HOLD);
                        end
                    end
                end
                M_STABLE: begin
                    if (lk == 0) model_enter(M_WAIT);
                    else if (dur == STABLE_N) begin
                        m_retry = 0;
                        model_enter(M_RUN);
                    end
                end
                M_RUN: begin
                    if (lk == 0) begin
                        if (m_loss < 15) m_loss++;
                        model_enter(M_HOLD);
                    end
                end
                default: ;
            endcase
        end
    endtask

    initial begin
        for (int i = 0; i < SYNC_N; i++) m_samp.push_back(0);
        forever begin
            @(posedge refclk);
            model_step();
        end
    end

    initial begin
        forever begin
            @(negedge refclk);
            if (m_valid) begin
                checkOutput("model pll_rst", int'(pll_rst), int'(m_phase == M_HOLD || m_phase == M_FAIL));
                checkOutput("model sys_reset", int'(sys_reset), int'(m_phase != M_RUN));
                checkOutput("model ready", int'(ready), int'(m_phase == M_RUN));
                checkOutput("model lock_fail", int'(lock_fail), int'(m_fail));
                checkOutput("model retry_count", int'(retry_count), m_retry);
                checkOutput("model lock_loss_count", int'(lock_loss_count), m_loss);
            end
        end
    end

    task automatic applyStimulus(input logic r, input logic q, input logic l);
        @(negedge refclk);
        rst        = r;
        req_reset  = q;
        pll_locked = l;
    endtask

    task automatic do_reset();
        applyStimulus(1'b1, 1'b0, 1'b0);
        repeat (2) @(negedge refclk);
        applyStimulus(1'b0, 1'b0, 1'b0);
    endtask

    // Counts negedge samples with pll_rst high, starting at the current negedge.
    task automatic count_pll_rst_high(output int n);
        n = 0;
        while (pll_rst === 1'b1 && n < 200) begin
            n++;
            @(negedge refclk);
        end
    endtask

    task automatic edges_until_ready(input logic level, output int n);
        n = 0;
        do begin
            @(negedge refclk);
            n++;
        end while (ready !== level && n < 200);
        if (ready !== level) n = -1;
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    int   n;
    logic pr[120];
    int   rc[120];
    logic lf[120];
    logic rd[120];
    int   pulses, high_cnt, left;
    logic lvl;

    initial begin
        // Clean lock
        do_reset();
        count_pll_rst_high(n);
        checkOutput("t1 hold length", n, 4);
        repeat (9) @(negedge refclk);
        applyStimulus(1'b0, 1'b0, 1'b1);
        edges_until_ready(1'b1, n);
        checkOutput("t1 lock latency", n, 11);
        checkOutput("t1 sys_reset", int'(sys_reset), 0);
        checkOutput("t1 retry_count", int'(retry_count), 0);

        // Glitch during STABLE, entered after one timeout so retry_count is 1
        do_reset();
        repeat (43) @(negedge refclk);
        applyStimulus(1'b0, 1'b0, 1'b1);
        checkOutput("t3 retry before lock", int'(retry_count), 1);
        repeat (4) @(negedge refclk);
        applyStimulus(1'b0, 1'b0, 1'b0);
        repeat (2) @(negedge refclk);
        applyStimulus(1'b0, 1'b0, 1'b1);
        checkOutput("t3 ready after glitch", int'(ready), 0);
        checkOutput("t3 retry unchanged", int'(retry_count), 1);
        edges_until_ready(1'b1, n);
        checkOutput("t3 fresh lock latency", n, 11);
        checkOutput("t3 retry cleared in run", int'(retry_count), 0);

        // Lock loss in RUN, repeated to saturate the loss counter
        for (int i = 1; i <= 16; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b0);
            edges_until_ready(1'b0, n);
            checkOutput("t4 ready fall latency", n, 3);
            checkOutput("t4 lock_loss_count", int'(lock_loss_count), (i < 15) ? i : 15);
            count_pll_rst_high(n);
            checkOutput("t4 hold length", n, 4);
            applyStimulus(1'b0, 1'b0, 1'b1);
            edges_until_ready(1'b1, n);
            checkOutput("t4 relock latency", n, 11);
        end

        // rst together with req_reset in the middle of STABLE
        applyStimulus(1'b0, 1'b0, 1'b0);
        edges_until_ready(1'b0, n);
        count_pll_rst_high(n);
        applyStimulus(1'b0, 1'b0, 1'b1);
        repeat (5) @(negedge refclk);
        applyStimulus(1'b1, 1'b1, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b1);
        checkOutput("t6 pll_rst", int'(pll_rst), 1);
        checkOutput("t6 sys_reset", int'(sys_reset), 1);
        checkOutput("t6 ready", int'(ready), 0);
        checkOutput("t6 lock_fail", int'(lock_fail), 0);
        checkOutput("t6 retry_count", int'(retry_count), 0);
        checkOutput("t6 lock_loss_count", int'(lock_loss_count), 0);
        count_pll_rst_high(n);
        checkOutput("t6 hold length", n, 4);

        // No lock at all: three hold pulses, then FAIL
        do_reset();
        for (int i = 0; i < 120; i++) begin
            pr[i] = pll_rst;
            rc[i] = int'(retry_count);
            lf[i] = lock_fail;
            rd[i] = ready;
            @(negedge refclk);
        end
        pulses   = 0;
        high_cnt = 0;
        for (int i = 0; i < 108; i++) begin
            if (pr[i] == 1'b1) high_cnt++;
            if (pr[i] == 1'b1 && (i == 0 || pr[i-1] == 1'b0)) pulses++;
        end
        checkOutput("t2 hold pulses", pulses, 3);
        checkOutput("t2 hold cycles", high_cnt, 12);
        checkOutput("t2 retry before first retry", rc[35], 0);
        checkOutput("t2 retry first", rc[36], 1);
        checkOutput("t2 retry second", rc[72], 2);
        checkOutput("t2 pll_rst before fail", int'(pr[107]), 0);
        checkOutput("t2 pll_rst in fail", int'(pr[108]), 1);
        checkOutput("t2 pll_rst stuck", int'(pr[119]), 1);
        checkOutput("t2 lock_fail before", int'(lf[107]), 0);
        checkOutput("t2 lock_fail set", int'(lf[108]), 1);
        checkOutput("t2 ready in fail", int'(rd[119]), 0);

        // req_reset out of FAIL
        applyStimulus(1'b0, 1'b1, 1'b0);
        checkOutput("t5 lock_fail before req", int'(lock_fail), 1);
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("t5 lock_fail cleared", int'(lock_fail), 0);
        checkOutput("t5 retry cleared", int'(retry_count), 0);
        count_pll_rst_high(n);
        checkOutput("t5 hold length", n, 4);
        applyStimulus(1'b0, 1'b0, 1'b1);
        edges_until_ready(1'b1, n);
        checkOutput("t5 lock latency", n, 11);

        // Randomized lock behaviour with occasional req_reset and rst
        left = 0;
        lvl  = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            if (left == 0) begin
                lvl  = ($urandom_range(0, 2) != 0);
                left = lvl ? int'($urandom_range(1, 80)) : int'($urandom_range(1, 48));
            end
            left--;
            applyStimulus(($urandom_range(0, 399) == 0), ($urandom_range(0, 149) == 0), lvl);
        end
        applyStimulus(1'b0, 1'b0, 1'b0);
        repeat (2) @(negedge refclk);

        $display("%0d/%0d checks passed", passed_checks, total_checks);
        $finish;
    end

endmodule

// File: doc/pll_reset_sequencer.md
Name: pll_reset_sequencer

Overview:
Drives the reset input of the core PLL and consumes its asynchronous locked output. It runs in the reference-clock domain and holds the PLL in reset for a fixed interval, then waits for lock, with a timeout and retry. It requires lock to stay stable before releasing the system reset that gates the CPU, draw-queue, VRAM and video domains. Lock loss, retry exhaustion and software re-sequencing requests are handled explicitly.

Parameters:
RST_HOLD_CYCLES, 16, cycles pll_rst is held high per attempt (>=2)
LOCK_TIMEOUT_CYCLES, 65536, max cycles in WAIT_LOCK before a retry (~0.88 ms at 74.25 MHz)
LOCK_STABLE_CYCLES, 1024, consecutive synchronized-locked cycles required before RUN
MAX_RETRIES, 7, timeouts tolerated before FAIL (retry_count width 4, so <=15)
SYNC_STAGES, 2, flops in the locked synchronizer (>=2)

Ports:
refclk  in  1  reference clock; the only clock
rst  in  1  synchronous, active-high reset
pll_locked  in  1  PLL lock indication, asynchronous to refclk
req_reset  in  1  single-cycle request to restart the sequence
pll_rst  out  1  reset to PLL, active-high
sys_reset  out  1  active-high reset to downstream logic
ready  out  1  high only in RUN
lock_fail  out  1  sticky, set on retry exhaustion
retry_count  out  4  timeouts since last successful lock
lock_loss_count  out  4  lock losses while in RUN, saturating at 15

Behaviour:
- Single clock refclk. Reset is synchronous and active-high on rst, per the already-decided interface.
- Reset values on rst=1: state=HOLD, counter=0, synchronizer flops=0, pll_rst=1, sys_reset=1, ready=0, lock_fail=0, retry_count=0, lock_loss_count=0.
- Priority: rst > req_reset > normal FSM.
- pll_locked passes through SYNC_STAGES flops to produce lk. FSM logic uses only lk.
- All outputs are registered and update on the same edge as the state register. They are a function of the state and counter registers only.
- sys_reset = (state != RUN). ready = (state == RUN). pll_rst = (state == HOLD || state == FAIL).
- Single down-counter, width clog2 of the largest cycle parameter. It is cleared on every state transition.

FSM states:
- HOLD: counts RST_HOLD_CYCLES cycles, then moves to WAIT_LOCK. pll_rst is high for exactly RST_HOLD_CYCLES cycles after rst deasserts.
- WAIT_LOCK:
  - lk=1: moves to STABLE on the next edge.
  - Otherwise, after LOCK_TIMEOUT_CYCLES cycles: if retry_count == MAX_RETRIES, moves to FAIL and sets lock_fail. Else retry_count increments and the FSM moves to HOLD.
- STABLE:
  - lk=0 on any cycle: moves to WAIT_LOCK with the timeout restarted. retry_count is unchanged.
  - After LOCK_STABLE_CYCLES consecutive lk=1 cycles: moves to RUN and clears retry_count.
- RUN: lk=0 increments lock_loss_count (saturating) and moves to HOLD.
- FAIL: terminal. pll_rst=1, sys_reset=1, lock_fail=1. Exits only via rst or req_reset.
- req_reset=1 in any state: moves to HOLD with counter=0, clears retry_count and lock_fail, keeps lock_loss_count. In HOLD it restarts the hold interval.
- Lock latency: pll_locked rising at edge k (held high) gives ready=1 after exactly SYNC_STAGES+1+LOCK_STABLE_CYCLES edges.
- Lock loss in RUN: ready falls and sys_reset rises SYNC_STAGES+1 edges after pll_locked falls.

Decomposition:
- Shared package pll_seq_pkg holds:
  - state enum: HOLD, WAIT_LOCK, STABLE, RUN, FAIL
  - counter width function
  - saturating-increment helper
- Sub-module bit_synchronizer: parameterized SYNC_STAGES flop chain with synchronous reset to 0. It is reused for other cross-domain single bits.

Test Plan:
Bench parameters: RST_HOLD_CYCLES=4, LOCK_TIMEOUT_CYCLES=32, LOCK_STABLE_CYCLES=8, MAX_RETRIES=2, SYNC_STAGES=2.
1. Clean lock: release rst, raise pll_locked 10 cycles after pll_rst falls.
   - pll_rst high exactly 4 cycles.
   - ready and !sys_reset exactly 11 edges after locked rises.
   - retry_count=0.
2. No lock: pll_locked held 0.
   - Three HOLD pulses of 4 cycles each.
   - retry_count reads 1, then 2.
   - After the third 32-cycle timeout: lock_fail=1, pll_rst stuck high, ready=0.
3. Glitch during STABLE: locked low for 3 cycles at STABLE count 5.
   - Returns to WAIT_LOCK with no ready pulse.
   - ready is asserted only after a fresh 8 consecutive lk cycles.
   - retry_count unchanged.
4. Loss in RUN: drop pll_locked.
   - ready falls 3 edges later.
   - lock_loss_count=1 and pll_rst high 4 cycles.
   - Relock returns to RUN.
   - Repeat 16 times: lock_loss_count saturates at 15.
5. req_reset in FAIL:
   - lock_fail clears and retry_count=0 on the next edge.
   - pll_rst high 4 more cycles, then normal lock reaches RUN.
6. rst and req_reset asserted on the same cycle mid-STABLE:
   - All outputs take their reset values, including lock_loss_count=0.
   - HOLD restarts for 4 cycles.
